// File: rtl/fib_checker.sv
// Checks an incoming term stream against the Fibonacci recurrence modulo 2^WIDTH.
// It reports a one-cycle verdict per accepted term and raises a sticky fail flag on the first mismatch.
module fib_checker #(
    parameter int WIDTH       = 8,
    parameter bit STRICT_SEED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             res_valid,
    output logic             res_ok,
    output logic             res_err,
    output logic             fail,
    output logic [7:0]       term_count,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {IDLE, SEED, TRACK, FAIL} state_t;

    localparam logic [WIDTH-1:0] SEED_EXP = STRICT_SEED ? WIDTH'(1) : '0;

    state_t           state;
    logic [WIDTH-1:0] cur;
    logic             accept;
    logic             seed_ok;
    logic             match;

    assign in_ready = (state != FAIL);
    assign fail     = (state == FAIL);
    assign accept   = in_valid && in_ready;

    always_comb begin
        seed_ok = !STRICT_SEED || (in_data == WIDTH'(1));
        match   = (state == TRACK) ? (in_data == expected) : seed_ok;
    end

    // Only the latest term is stored; 'expected' already holds prev + cur,
    // so the next expectation is simply cur + the newly accepted term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            expected   <= SEED_EXP;
            term_count <= '0;
            res_valid  <= 1'b0;
            res_ok     <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            res_err   <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                cur        <= '0;
                expected   <= SEED_EXP;
                term_count <= '0;
            end else if (accept) begin
                res_valid <= 1'b1;
                res_ok    <= match;
                res_err   <= !match;
                if (match) begin
                    if (term_count != 8'hFF) begin
                        term_count <= term_count + 8'd1;
                    end
                    case (state)
                        IDLE: begin
                            state <= SEED;
                            cur   <= in_data;
                        end
                        SEED, TRACK: begin
                            state    <= TRACK;
                            cur      <= in_data;
                            expected <= cur + in_data;
                        end
                        default: ;
                    endcase
                end else begin
                    state <= FAIL;
                end
            end
        end
    end

endmodule

// File: tb/tb_fib_checker.sv
// Directed bench for fib_checker: one strict-seed and one free-seed instance share clock, reset and data bus.
module tb_fib_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] data;
    logic       valid;
    logic       clear;

    logic       v1, c1, rdy1, rv1, rok1, rerr1, fail1;
    logic       v0, c0, rdy0, rv0, rok0, rerr0, fail0;
    logic [7:0] cnt1, exp1, cnt0, exp0;

    logic       o_ready, o_valid, o_ok, o_err, o_fail;
    logic [7:0] o_cnt, o_exp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign v1 = valid && sel;
    assign c1 = clear && sel;
    assign v0 = valid && !sel;
    assign c0 = clear && !sel;

    assign o_ready = sel ? rdy1  : rdy0;
    assign o_valid = sel ? rv1   : rv0;
    assign o_ok    = sel ? rok1  : rok0;
    assign o_err   = sel ? rerr1 : rerr0;
    assign o_fail  = sel ? fail1 : fail0;
    assign o_cnt   = sel ? cnt1  : cnt0;
    assign o_exp   = sel ? exp1  : exp0;

    fib_checker #(.WIDTH(8), .STRICT_SEED(1'b1)) dut_strict (
        .clk(clk), .rst(rst), .in_data(data), .in_valid(v1), .in_ready(rdy1),
        .clear(c1), .res_valid(rv1), .res_ok(rok1), .res_err(rerr1),
        .fail(fail1), .term_count(cnt1), .expected(exp1)
    );

    fib_checker #(.WIDTH(8), .STRICT_SEED(1'b0)) dut_free (
        .clk(clk), .rst(rst), .in_data(data), .in_valid(v0), .in_ready(rdy0),
        .clear(c0), .res_valid(rv0), .res_ok(rok0), .res_err(rerr0),
        .fail(fail0), .term_count(cnt0), .expected(exp0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Presents one term; the verdict must be visible right after the accepting edge.
    task automatic beat(input logic [7:0] v, input logic ok, input string tag);
        data  = v;
        valid = 1'b1;
        @(posedge clk); #1;
        check(tag, {29'b0, o_valid, o_ok, o_err}, {29'b0, 1'b1, ok, !ok});
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("gap_no_verdict", {31'b0, o_valid}, 32'd0);
        end
    endtask

    task automatic do_clear();
        valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_no_verdict", {31'b0, o_valid}, 32'd0);
        check("clear_count", {24'b0, o_cnt}, 32'd0);
    endtask

    logic [7:0] fib [15] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                             8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};
    logic [7:0] lucas [5] = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd7};

    initial begin
        sel   = 1'b1;
        rst   = 1'b1;
        valid = 1'b0;
        clear = 1'b0;
        data  = '0;
        #12;
        check("rst_ready", {31'b0, rdy1}, 32'd1);
        check("rst_expected_strict", {24'b0, exp1}, 32'd1);
        check("rst_expected_free", {24'b0, exp0}, 32'd0);
        check("rst_count", {24'b0, cnt1}, 32'd0);
        check("rst_flags", {28'b0, rv1, rok1, rerr1, fail1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // golden stream, back-to-back
        for (int i = 0; i < 7; i++) beat(fib[i], 1'b1, "golden_verdict");
        valid = 1'b0;
        check("golden_count", {24'b0, o_cnt}, 32'd7);
        check("golden_expected", {24'b0, o_exp}, 32'd21);
        check("golden_fail", {31'b0, o_fail}, 32'd0);

        // wrap-around past 233: 144+233 -> 121, 233+121 -> 98, 121+98 -> 219
        do_clear();
        for (int i = 0; i < 15; i++) beat(fib[i], 1'b1, "wrap_verdict");
        valid = 1'b0;
        check("wrap_count", {24'b0, o_cnt}, 32'd15);
        check("wrap_expected", {24'b0, o_exp}, 32'd219);

        // mismatch then ignored input then clear
        do_clear();
        beat(8'd1, 1'b1, "mm_t0");
        beat(8'd1, 1'b1, "mm_t1");
        beat(8'd2, 1'b1, "mm_t2");
        beat(8'd4, 1'b0, "mm_err");
        valid = 1'b0;
        check("mm_fail", {31'b0, o_fail}, 32'd1);
        check("mm_ready", {31'b0, o_ready}, 32'd0);
        check("mm_expected", {24'b0, o_exp}, 32'd3);
        check("mm_count", {24'b0, o_cnt}, 32'd3);
        data  = 8'd5;
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("fail_ignores_valid", {30'b0, o_valid, o_fail}, 32'd1);
        end
        do_clear();
        check("mm_clear_ready", {31'b0, o_ready}, 32'd1);
        check("mm_clear_fail", {31'b0, o_fail}, 32'd0);

        // strict seed rejects a first term of 2
        beat(8'd2, 1'b0, "strict_seed_err");
        valid = 1'b0;
        check("strict_seed_fail", {31'b0, o_fail}, 32'd1);
        check("strict_seed_expected", {24'b0, o_exp}, 32'd1);
        do_clear();

        // clear collides with an accepted beat: term discarded, no verdict
        for (int i = 0; i < 4; i++) beat(fib[i], 1'b1, "coll_pre");
        data  = 8'd5;
        valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        valid = 1'b0;
        check("coll_no_verdict", {31'b0, o_valid}, 32'd0);
        check("coll_count", {24'b0, o_cnt}, 32'd0);
        check("coll_expected", {24'b0, o_exp}, 32'd1);
        check("coll_ready", {31'b0, o_ready}, 32'd1);
        for (int i = 0; i < 4; i++) beat(fib[i], 1'b1, "coll_restart");

        // asynchronous reset between edges while a verdict pulse is showing
        data  = 8'd5;
        #3 rst = 1'b1;
        #1;
        check("async_rst_verdict", {29'b0, o_valid, o_ok, o_err}, 32'd0);
        check("async_rst_count", {24'b0, o_cnt}, 32'd0);
        check("async_rst_expected", {24'b0, o_exp}, 32'd1);
        check("async_rst_ready", {31'b0, o_ready}, 32'd1);
        valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        beat(8'd1, 1'b1, "post_rst_t0");
        valid = 1'b0;
        check("post_rst_count", {24'b0, o_cnt}, 32'd1);

        // golden stream with random stalls
        do_clear();
        for (int i = 0; i < 7; i++) begin
            beat(fib[i], 1'b1, "stall_verdict");
            idle($urandom_range(0, 3));
        end
        check("stall_count", {24'b0, o_cnt}, 32'd7);
        check("stall_expected", {24'b0, o_exp}, 32'd21);

        // free-seed instance: Lucas sequence
        sel = 1'b0;
        for (int i = 0; i < 5; i++) beat(lucas[i], 1'b1, "lucas_verdict");
        valid = 1'b0;
        check("lucas_count", {24'b0, o_cnt}, 32'd5);
        check("lucas_expected", {24'b0, o_exp}, 32'd11);

        // saturation: all-zero stream is a valid sequence with seeds 0,0
        do_clear();
        for (int i = 0; i < 300; i++) beat(8'd0, 1'b1, "sat_verdict");
        valid = 1'b0;
        check("sat_count", {24'b0, o_cnt}, 32'd255);
        check("sat_expected", {24'b0, o_exp}, 32'd0);
        check("sat_fail", {31'b0, o_fail}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected finish");
        $fatal(1);
    end

endmodule
